// File: rtl/data_memory_pkg.sv
// rtl/data_memory_pkg.sv - shared sizing constants and word type for data_memory
package data_memory_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_ADDR_WIDTH = 8;

    // Byte address -> word index: drop the low WORD_BYTES_LOG2 bits.
    localparam int WORD_BYTES      = 4;
    localparam int WORD_BYTES_LOG2 = 2;

    typedef logic [DEFAULT_DATA_WIDTH-1:0] word_t;

endpackage

// File: rtl/data_memory.sv
// rtl/data_memory.sv - word-addressed data memory, sync write, combinational gated read; optional DATA_MEMORY_ALIGN_CHECK_EN
module data_memory
    import data_memory_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] Address,
    input  logic                  MemRead,
    output logic [DATA_WIDTH-1:0] ReadData,
    input  logic                  MemWrite,
`ifdef DATA_MEMORY_ALIGN_CHECK_EN
    output logic                  misaligned,
`endif
    input  logic [DATA_WIDTH-1:0] writeData
);

    localparam int INDEX_WIDTH = ADDR_WIDTH - WORD_BYTES_LOG2;
    localparam int DEPTH       = 1 << INDEX_WIDTH;

    logic [DATA_WIDTH-1:0]  mem_q [DEPTH];
    logic [INDEX_WIDTH-1:0] word_index;
    logic                   write_en;
    logic                   read_en;

    // Every byte address maps onto some word; there is no out-of-range case.
    assign word_index = Address[ADDR_WIDTH-1:WORD_BYTES_LOG2];

`ifdef DATA_MEMORY_ALIGN_CHECK_EN
    // Flag sub-word addressing on any active access; such accesses are squashed.
    assign misaligned = (MemRead | MemWrite) & (Address[WORD_BYTES_LOG2-1:0] != '0);
    assign write_en   = MemWrite & ~misaligned;
    assign read_en    = MemRead & ~misaligned;
`else
    // Low address bits are deliberately ignored: whole-word accesses only.
    logic unused_low_bits;
    assign unused_low_bits = ^Address[WORD_BYTES_LOG2-1:0];
    assign write_en        = MemWrite;
    assign read_en         = MemRead;
`endif

    // Storage: reset clears every word at once, otherwise one word per edge is written.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (write_en) begin
            mem_q[word_index] <= writeData;
        end
    end

    // Read port: combinational, forced to zero when not strobed (no write bypass).
    always_comb begin
        ReadData = '0;
        if (read_en) begin
            ReadData = mem_q[word_index];
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// tb/tb_data_memory.sv - directed self-checking bench for data_memory
module tb_data_memory;
    import data_memory_pkg::*;

    logic        clock;
    logic        reset;
    logic [7:0]  Address;
    logic        MemRead;
    logic        MemWrite;
    word_t       writeData;
    word_t       ReadData;
`ifdef DATA_MEMORY_ALIGN_CHECK_EN
    logic        misaligned;
`endif

    int n_checks = 0;
    int n_passed = 0;

    data_memory dut (
        .clock     (clock),
        .reset     (reset),
        .Address   (Address),
        .MemRead   (MemRead),
        .ReadData  (ReadData),
        .MemWrite  (MemWrite),
`ifdef DATA_MEMORY_ALIGN_CHECK_EN
        .misaligned(misaligned),
`endif
        .writeData (writeData)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_passed++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic read_check(input string tag, input logic [7:0] addr, input logic [31:0] exp);
        Address = addr;
        MemRead = 1'b1;
        #1;
        check(tag, ReadData, exp);
    endtask

    logic [7:0]  burst_addr [5] = '{8'h04, 8'h08, 8'h0C, 8'h18, 8'h1C};
    logic [31:0] burst_data [5] = '{32'h2, 32'h5, 32'h9, 32'h7, 32'hA};
    logic [7:0]  rb_addr    [5] = '{8'h18, 8'h04, 8'h1C, 8'h08, 8'h0C};
    logic [31:0] rb_data    [5] = '{32'h7, 32'h2, 32'hA, 32'h5, 32'h9};

    initial begin
        reset     = 1'b1;
        Address   = 8'h00;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        writeData = '0;

        // Reset state
        @(negedge clock);
        read_check("reset_rd_04", 8'h04, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        read_check("post_reset_rd_1c", 8'h1C, 32'h0);

        // Write burst on consecutive edges
        MemRead = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            Address   = burst_addr[i];
            writeData = burst_data[i];
            MemWrite  = 1'b1;
        end
        @(negedge clock);
        MemWrite = 1'b0;

        // Read-back in scrambled order
        for (int i = 0; i < 5; i++) begin
            read_check($sformatf("readback_%02h", rb_addr[i]), rb_addr[i], rb_data[i]);
        end

        // Read gating, no clock edge in between
        Address = 8'h18;
        MemRead = 1'b0;
        #1;
        check("gate_off_18", ReadData, 32'h0);
        MemRead = 1'b1;
        #1;
        check("gate_on_18", ReadData, 32'h7);

        // Write disabled for three edges
        Address   = 8'h04;
        writeData = 32'hDEADBEEF;
        MemWrite  = 1'b0;
        repeat (3) @(negedge clock);
        read_check("wr_disabled_04", 8'h04, 32'h2);

        // Same-cycle read and write: old data before the edge, new after
        Address   = 8'h08;
        writeData = 32'h1234;
        MemRead   = 1'b1;
        MemWrite  = 1'b1;
        #1;
        check("rw_before_edge", ReadData, 32'h5);
        @(posedge clock);
        #1;
        check("rw_after_edge", ReadData, 32'h1234);
        @(negedge clock);
        MemWrite = 1'b0;

        // Top of the address range
        Address   = 8'hFC;
        writeData = 32'hCAFEF00D;
        MemWrite  = 1'b1;
        @(negedge clock);
        MemWrite = 1'b0;
        read_check("top_word_fc", 8'hFC, 32'hCAFEF00D);

        // Low address bits: aliasing or alignment rejection
        Address   = 8'h21;
        writeData = 32'hAB;
        MemRead   = 1'b0;
        MemWrite  = 1'b1;
        #1;
`ifdef DATA_MEMORY_ALIGN_CHECK_EN
        check("misaligned_21", {31'b0, misaligned}, 32'h1);
`endif
        @(negedge clock);
        MemWrite = 1'b0;
`ifdef DATA_MEMORY_ALIGN_CHECK_EN
        read_check("aligned_rd_20", 8'h20, 32'h0);
        check("aligned_flag_20", {31'b0, misaligned}, 32'h0);
        read_check("misaligned_rd_fe", 8'hFE, 32'h0);
`else
        read_check("alias_rd_20", 8'h20, 32'hAB);
        read_check("alias_rd_23", 8'h23, 32'hAB);
`endif

        // Mid-run asynchronous reset, with a write attempted during it
        #2;
        reset = 1'b1;
        #1;
        read_check("midrst_rd_04", 8'h04, 32'h0);
        read_check("midrst_rd_1c", 8'h1C, 32'h0);
        Address   = 8'h0C;
        writeData = 32'h55AA55AA;
        MemWrite  = 1'b1;
        @(negedge clock);
        MemWrite = 1'b0;
        reset    = 1'b0;
        @(negedge clock);
        read_check("after_rst_0c", 8'h0C, 32'h0);
        read_check("after_rst_18", 8'h18, 32'h0);
        read_check("after_rst_fc", 8'hFC, 32'h0);

        // Array usable again after reset
        Address   = 8'h1C;
        writeData = 32'h13579BDF;
        MemWrite  = 1'b1;
        @(negedge clock);
        MemWrite = 1'b0;
        read_check("rewrite_1c", 8'h1C, 32'h13579BDF);
        read_check("neighbour_18", 8'h18, 32'h0);

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
